// File: rtl/memctrl_if.sv
// memctrl_if: fetch and load/store request channels plus the byte-wide RAM/IO bus.
// master = requesters/memory side, slave = memctrl.
interface memctrl_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        lsb_enable;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_ready;
    logic [31:0] lsb_rdata;

    modport master (
        output mem_din, io_buffer_full,
        output if_enable, if_addr,
        output lsb_enable, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  if_ready, if_inst, lsb_ready, lsb_rdata
    );

    modport slave (
        input  mem_din, io_buffer_full,
        input  if_enable, if_addr,
        input  lsb_enable, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
        output mem_dout, mem_a, mem_wr,
        output if_ready, if_inst, lsb_ready, lsb_rdata
    );
endinterface

// File: rtl/memctrl.sv
// memctrl: arbitrates fetch and load/store requests onto one byte-wide RAM/IO port,
// serialising each access into bytes and reassembling little-endian words.
module memctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      clear,
    memctrl_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] STORE = 2'd3;
    localparam logic GRANT_LSB = 1'b0;
    localparam logic GRANT_IF  = 1'b1;

    logic [1:0]  state;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] buffer;
    logic [2:0]  n;
    logic [2:0]  k;
    logic        last_grant;
    logic        prev_rdy;
    logic [7:0]  held;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        if_ready_q;
    logic        lsb_ready_q;
    logic [31:0] if_inst_q;
    logic [31:0] lsb_rdata_q;

    logic [2:0]  lsb_n;
    logic        pick_if;
    logic        pick_lsb;
    logic        is_io;
    logic        grant_io;
    logic [7:0]  din;
    logic [1:0]  idx;
    logic [31:0] merged;
    logic [2:0]  k_inc;
    logic [7:0]  wbyte;

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_wr    = mem_wr_q & rdy_in;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.lsb_ready = lsb_ready_q;
    assign bus.lsb_rdata = lsb_rdata_q;

    assign pick_if  = bus.if_enable &&
                      (!bus.lsb_enable || last_grant == GRANT_LSB);
    assign pick_lsb = bus.lsb_enable && !pick_if;
    assign is_io    = base[17:16] == IO_SEL;
    assign grant_io = bus.lsb_addr[17:16] == IO_SEL;

    // The byte in flight when rdy_in dropped is parked in held, since the
    // RAM keeps reading the frozen address while we are paused.
    assign din    = prev_rdy ? bus.mem_din : held;
    assign idx    = k[1:0] - 2'd1;
    assign merged = buffer | ({24'b0, din} << {idx, 3'b000});
    assign k_inc  = k + {2'b00, mem_wr_q};

    always_comb begin
        lsb_n = 3'd4;
        case (bus.lsb_len)
            2'd0:    lsb_n = 3'd1;
            2'd1:    lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

    always_comb begin
        wbyte = wdata[7:0];
        case (k_inc[1:0])
            2'd0:    wbyte = wdata[7:0];
            2'd1:    wbyte = wdata[15:8];
            2'd2:    wbyte = wdata[23:16];
            default: wbyte = wdata[31:24];
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            base        <= '0;
            wdata       <= '0;
            buffer      <= '0;
            n           <= '0;
            k           <= '0;
            last_grant  <= GRANT_LSB;
            prev_rdy    <= 1'b1;
            held        <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            lsb_ready_q <= 1'b0;
            if_inst_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            prev_rdy    <= rdy_in;
            if_ready_q  <= 1'b0;
            lsb_ready_q <= 1'b0;
            if (!rdy_in && prev_rdy)
                held <= bus.mem_din;
            if (rdy_in) begin
                unique case (state)
                    IDLE: begin
                        if (!clear && (pick_if || pick_lsb)) begin
                            k      <= '0;
                            buffer <= '0;
                            if (pick_if) begin
                                state      <= FETCH;
                                last_grant <= GRANT_IF;
                                base       <= bus.if_addr;
                                n          <= 3'd4;
                                mem_a_q    <= bus.if_addr;
                            end else begin
                                last_grant <= GRANT_LSB;
                                base       <= bus.lsb_addr;
                                wdata      <= bus.lsb_wdata;
                                n          <= lsb_n;
                                mem_a_q    <= bus.lsb_addr;
                                if (bus.lsb_wr) begin
                                    state      <= STORE;
                                    mem_dout_q <= bus.lsb_wdata[7:0];
                                    mem_wr_q   <= !(grant_io && bus.io_buffer_full);
                                end else begin
                                    state <= LOAD;
                                end
                            end
                        end
                    end
                    FETCH, LOAD: begin
                        if (clear) begin
                            state   <= IDLE;
                            mem_a_q <= '0;
                        end else begin
                            k <= k + 3'd1;
                            if (k != 3'd0)
                                buffer <= merged;
                            if (k + 3'd1 < n)
                                mem_a_q <= base + {29'b0, k} + 32'd1;
                            else
                                mem_a_q <= '0;
                            if (k == n) begin
                                state <= IDLE;
                                if (state == FETCH) begin
                                    if_ready_q <= 1'b1;
                                    if_inst_q  <= merged;
                                end else begin
                                    lsb_ready_q <= 1'b1;
                                    lsb_rdata_q <= merged;
                                end
                            end
                        end
                    end
                    STORE: begin
                        // k only advances on a cycle that actually wrote.
                        if (k_inc == n) begin
                            state       <= IDLE;
                            mem_a_q     <= '0;
                            mem_dout_q  <= '0;
                            mem_wr_q    <= 1'b0;
                            lsb_ready_q <= 1'b1;
                        end else begin
                            k          <= k_inc;
                            mem_a_q    <= base + {29'b0, k_inc};
                            mem_dout_q <= wbyte;
                            mem_wr_q   <= !(is_io && bus.io_buffer_full);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed scenarios for memctrl; a negedge monitor pops expected
// ready events (data and cycle) from per-channel scoreboard queues.
module tb_memctrl;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_if_ready = 0;

    exp_t q_if[$];
    exp_t q_lsb[$];
    exp_t e_if;
    exp_t e_lsb;
    logic [31:0] alog[$];
    logic [39:0] wlog[$];
    logic [7:0]  ram [logic [31:0]];

    memctrl_if bus();

    memctrl #(.IO_SEL(2'b11)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clear  (clr),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read every cycle, write when mem_wr is high.
    always @(posedge clk) begin
        if (rdy && bus.mem_wr) begin
            ram[bus.mem_a] = bus.mem_dout;
            wlog.push_back({bus.mem_a, bus.mem_dout});
        end else if (rdy && bus.mem_a != 32'h0) begin
            alog.push_back(bus.mem_a);
        end
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.if_ready) begin
            n_if_ready++;
            if (q_if.size() == 0) begin
                chk("if_ready unexpected", 1, 0);
            end else begin
                e_if = q_if.pop_front();
                chk("if_inst", bus.if_inst, e_if.data);
                chk("if_ready cycle", cyc, e_if.cyc);
            end
        end
        if (bus.lsb_ready) begin
            if (q_lsb.size() == 0) begin
                chk("lsb_ready unexpected", 1, 0);
            end else begin
                e_lsb = q_lsb.pop_front();
                chk("lsb_rdata", bus.lsb_rdata, e_lsb.data);
                chk("lsb_ready cycle", cyc, e_lsb.cyc);
            end
        end
    end

    task automatic wait_ready(input bit is_if, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = is_if ? bus.if_ready : bus.lsb_ready;
        end
        if (!got) chk(name, 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " mem_wr"}, bus.mem_wr, 0);
        chk({tag, " mem_a"}, bus.mem_a, 0);
        chk({tag, " mem_dout"}, bus.mem_dout, 0);
        chk({tag, " if_ready"}, bus.if_ready, 0);
        chk({tag, " lsb_ready"}, bus.lsb_ready, 0);
        chk({tag, " if_inst"}, bus.if_inst, 0);
        chk({tag, " lsb_rdata"}, bus.lsb_rdata, 0);
    endtask

    function automatic logic [31:0] a_at(input int i);
        return (i < alog.size()) ? alog[i] : 32'h0;
    endfunction

    function automatic logic [39:0] w_at(input int i);
        return (i < wlog.size()) ? wlog[i] : 40'h0;
    endfunction

    initial begin
        logic [7:0] sb [4];
        int t;
        int base_ready;
        sb = '{8'h78, 8'h56, 8'h34, 8'h12};
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ram[32'h1100] = 8'h93; ram[32'h1101] = 8'h00;
        ram[32'h1102] = 8'h10; ram[32'h1103] = 8'h00;
        ram[32'h1200] = 8'h01; ram[32'h1201] = 8'h02;
        ram[32'h1202] = 8'h03; ram[32'h1203] = 8'h04;
        ram[32'h2000] = 8'haa;
        ram[32'h2001] = 8'h34; ram[32'h2002] = 8'h82;
        ram[32'h2003] = 8'hbb;
        ram[32'h2100] = 8'h11; ram[32'h2101] = 8'h22;
        ram[32'h2102] = 8'h33; ram[32'h2103] = 8'h44;
        ram[32'h2200] = 8'hfe;
        bus.io_buffer_full = 1'b0;
        bus.if_enable = 1'b0;
        bus.if_addr = '0;
        bus.lsb_enable = 1'b0;
        bus.lsb_wr = 1'b0;
        bus.lsb_addr = '0;
        bus.lsb_len = '0;
        bus.lsb_wdata = '0;

        #1 rst = 1'b1;
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // fetch 0x1000
        @(negedge clk);
        alog.delete(); wlog.delete();
        bus.if_addr = 32'h1000; bus.if_enable = 1'b1;
        q_if.push_back('{32'h00000513, cyc + 6});
        wait_ready(1, "fetch timeout");
        bus.if_enable = 1'b0;
        chk("fetch addr count", alog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fetch addr", a_at(i), 32'h1000 + i);
        chk("fetch no write", wlog.size(), 0);

        // load half at 0x2001
        alog.delete();
        bus.lsb_addr = 32'h2001; bus.lsb_len = 2'd1;
        bus.lsb_wr = 1'b0; bus.lsb_enable = 1'b1;
        q_lsb.push_back('{32'h00008234, cyc + 4});
        wait_ready(0, "load half timeout");
        bus.lsb_enable = 1'b0;
        chk("load addr count", alog.size(), 2);
        chk("load addr0", a_at(0), 32'h2001);
        chk("load addr1", a_at(1), 32'h2002);

        // IO store with two stall cycles
        @(negedge clk);
        alog.delete(); wlog.delete();
        t = cyc + 1;
        bus.lsb_addr = 32'h30000; bus.lsb_len = 2'd2;
        bus.lsb_wdata = 32'h12345678; bus.lsb_wr = 1'b1;
        bus.lsb_enable = 1'b1;
        q_lsb.push_back('{32'h00008234, t + 6});
        @(negedge clk);
        @(negedge clk);
        bus.io_buffer_full = 1'b1;
        @(negedge clk);
        chk("io stall mem_wr", bus.mem_wr, 0);
        @(negedge clk);
        bus.io_buffer_full = 1'b0;
        wait_ready(0, "io store timeout");
        bus.lsb_enable = 1'b0; bus.lsb_wr = 1'b0;
        chk("io store writes", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("io store byte", w_at(i), {32'h30000 + i, sb[i]});
        chk("io stall cycles", alog.size(), 2);

        // both requesters held from reset: grants must alternate
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t = cyc + 1;
        bus.if_addr = 32'h1100; bus.if_enable = 1'b1;
        bus.lsb_addr = 32'h2100; bus.lsb_len = 2'd2;
        bus.lsb_wr = 1'b0; bus.lsb_enable = 1'b1;
        q_if.push_back('{32'h00100093, t + 5});
        q_lsb.push_back('{32'h44332211, t + 11});
        q_if.push_back('{32'h04030201, t + 17});
        q_lsb.push_back('{32'h000000fe, t + 20});
        fork
            begin
                wait_ready(1, "alt fetch0 timeout");
                bus.if_addr = 32'h1200;
                wait_ready(1, "alt fetch1 timeout");
                bus.if_enable = 1'b0;
            end
            begin
                wait_ready(0, "alt load0 timeout");
                bus.lsb_addr = 32'h2200; bus.lsb_len = 2'd0;
                wait_ready(0, "alt load1 timeout");
                bus.lsb_enable = 1'b0;
            end
        join

        // clear during the 2nd fetch byte
        @(negedge clk);
        alog.delete();
        base_ready = n_if_ready;
        bus.if_addr = 32'h1000; bus.if_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1; bus.if_enable = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("clear idle mem_a", bus.mem_a, 0);
        repeat (8) @(negedge clk);
        chk("clear no if_ready", n_if_ready - base_ready, 0);
        chk("clear if_inst kept", bus.if_inst, 32'h04030201);
        chk("clear addr count", alog.size(), 2);

        // clear during a store must not stop it
        wlog.delete();
        t = cyc + 1;
        bus.lsb_addr = 32'h3000; bus.lsb_len = 2'd1;
        bus.lsb_wdata = 32'h0000beef; bus.lsb_wr = 1'b1;
        bus.lsb_enable = 1'b1;
        q_lsb.push_back('{32'h000000fe, t + 2});
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_ready(0, "clear store timeout");
        bus.lsb_enable = 1'b0; bus.lsb_wr = 1'b0;
        chk("clear store writes", wlog.size(), 2);
        chk("clear store b0", w_at(0), {32'h3000, 8'hef});
        chk("clear store b1", w_at(1), {32'h3001, 8'hbe});

        // load word paused by rdy_in for 3 cycles
        @(negedge clk);
        t = cyc + 1;
        bus.lsb_addr = 32'h2100; bus.lsb_len = 2'd2;
        bus.lsb_wr = 1'b0; bus.lsb_enable = 1'b1;
        q_lsb.push_back('{32'h44332211, t + 8});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        wait_ready(0, "paused load timeout");
        bus.lsb_enable = 1'b0;

        // reset in the middle of a store
        @(negedge clk);
        bus.lsb_addr = 32'h3100; bus.lsb_len = 2'd2;
        bus.lsb_wdata = 32'hcafef00d; bus.lsb_wr = 1'b1;
        bus.lsb_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("store active mem_wr", bus.mem_wr, 1);
        rst = 1'b1;
        bus.lsb_enable = 1'b0; bus.lsb_wr = 1'b0;
        #1;
        check_zero("mid-store reset");
        @(negedge clk);
        rst = 1'b0;

        // service resumes after reset
        bus.if_addr = 32'h1000; bus.if_enable = 1'b1;
        q_if.push_back('{32'h00000513, cyc + 6});
        wait_ready(1, "post-reset fetch timeout");
        bus.if_enable = 1'b0;
        repeat (3) @(negedge clk);

        chk("if queue drained", q_if.size(), 0);
        chk("lsb queue drained", q_lsb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
